// File: rtl/filtro_defs.sv
// ============================================================================
//  Module   : filtro_defs (package)
//  Purpose  : Shared FILTRO constants: data width and source-select codes
//             used by the source-select mux and the write-back sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package filtro_defs;

    localparam int CANT_BITS_DEFAULT = 25;
    localparam int N_OUT_REGS        = 6;

    localparam logic [3:0] SEL_U    = 4'b0000;
    localparam logic [3:0] SEL_A    = 4'b0001;
    localparam logic [3:0] SEL_B    = 4'b0010;
    localparam logic [3:0] SEL_C    = 4'b0101;
    localparam logic [3:0] SEL_D    = 4'b0110;
    localparam logic [3:0] SEL_E    = 4'b0111;
    // Unused code: the source-select mux outputs zero for it.
    localparam logic [3:0] SEL_NONE = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/demux_out_seq_if.sv
// ============================================================================
//  Module   : demux_out_seq_if
//  Purpose  : Bundle between the FILTRO datapath and the write-back sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface demux_out_seq_if
    import filtro_defs::*;
#(
    parameter int CANT_BITS = CANT_BITS_DEFAULT
);
    logic                        start;
    logic signed [CANT_BITS-1:0] res;
    logic        [3:0]           selec;
    logic signed [CANT_BITS-1:0] a;
    logic signed [CANT_BITS-1:0] b;
    logic signed [CANT_BITS-1:0] c;
    logic signed [CANT_BITS-1:0] d;
    logic signed [CANT_BITS-1:0] e;
    logic signed [CANT_BITS-1:0] y;
    logic                        busy;
    logic                        done;

    // Datapath side: issues sample ticks and supplies the arithmetic result.
    modport master (
        output start, res,
        input  selec, a, b, c, d, e, y, busy, done
    );

    // Sequencer side.
    modport slave (
        input  start, res,
        output selec, a, b, c, d, e, y, busy, done
    );

endinterface

`default_nettype wire

// File: rtl/reg_bank_out.sv
// ============================================================================
//  Module   : reg_bank_out
//  Purpose  : Bank of N_REGS data registers with synchronous clear, written
//             from one shared data word under a one-hot write enable.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_bank_out
    import filtro_defs::*;
#(
    parameter int WIDTH  = CANT_BITS_DEFAULT,
    parameter int N_REGS = N_OUT_REGS
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    input  wire logic [N_REGS-1:0]             i_we,
    input  wire logic [WIDTH-1:0]              i_data,
    output logic      [N_REGS-1:0][WIDTH-1:0]  o_q
);

    generate
        for (genvar i = 0; i < N_REGS; i++) begin : g_reg
            logic [WIDTH-1:0] r_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_q <= '0;
                end else if (i_we[i]) begin
                    r_q <= i_data;
                end
            end

            assign o_q[i] = r_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/demux_out_seq.sv
// ============================================================================
//  Module   : demux_out_seq
//  Purpose  : FILTRO write-back sequencer. Steps the input selector through
//             the six source codes and captures res into the matching register.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_out_seq
    import filtro_defs::*;
#(
    parameter int CANT_BITS = CANT_BITS_DEFAULT
) (
    input  wire logic        clk,
    input  wire logic        reset,
    demux_out_seq_if.slave   bus
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_U    = 3'd1;
    localparam logic [2:0] ST_A    = 3'd2;
    localparam logic [2:0] ST_B    = 3'd3;
    localparam logic [2:0] ST_C    = 3'd4;
    localparam logic [2:0] ST_D    = 3'd5;
    localparam logic [2:0] ST_E    = 3'd6;
    localparam logic [2:0] ST_FIN  = 3'd7;

    logic [2:0]                          r_state;
    logic [2:0]                          w_state_nxt;
    logic [3:0]                          r_selec;
    logic [3:0]                          w_selec_nxt;
    logic [N_OUT_REGS-1:0]               w_we;
    logic [N_OUT_REGS-1:0][CANT_BITS-1:0] w_q;

    // Start is only looked at in IDLE, so ticks during a sequence are dropped.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_state_nxt = ST_U;
            ST_U:    w_state_nxt = ST_A;
            ST_A:    w_state_nxt = ST_B;
            ST_B:    w_state_nxt = ST_C;
            ST_C:    w_state_nxt = ST_D;
            ST_D:    w_state_nxt = ST_E;
            ST_E:    w_state_nxt = ST_FIN;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // selec is registered alongside the state so it is glitch-free at the mux.
    always_comb begin
        w_selec_nxt = SEL_NONE;
        case (w_state_nxt)
            ST_U:    w_selec_nxt = SEL_U;
            ST_A:    w_selec_nxt = SEL_A;
            ST_B:    w_selec_nxt = SEL_B;
            ST_C:    w_selec_nxt = SEL_C;
            ST_D:    w_selec_nxt = SEL_D;
            ST_E:    w_selec_nxt = SEL_E;
            default: w_selec_nxt = SEL_NONE;
        endcase
    end

    // res belongs to the current step, so it is written at the edge leaving it.
    always_comb begin
        w_we = '0;
        case (r_state)
            ST_U:    w_we = 6'b000001;
            ST_A:    w_we = 6'b000010;
            ST_B:    w_we = 6'b000100;
            ST_C:    w_we = 6'b001000;
            ST_D:    w_we = 6'b010000;
            ST_E:    w_we = 6'b100000;
            default: w_we = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_selec <= SEL_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_selec <= w_selec_nxt;
        end
    end

    reg_bank_out #(
        .WIDTH  (CANT_BITS),
        .N_REGS (N_OUT_REGS)
    ) u_bank (
        .clk    (clk),
        .rst    (reset),
        .i_we   (w_we),
        .i_data (bus.res),
        .o_q    (w_q)
    );

    assign bus.selec = r_selec;
    assign bus.a     = w_q[0];
    assign bus.b     = w_q[1];
    assign bus.c     = w_q[2];
    assign bus.d     = w_q[3];
    assign bus.e     = w_q[4];
    assign bus.y     = w_q[5];
    assign bus.busy  = (r_state != ST_IDLE);
    assign bus.done  = (r_state == ST_FIN);

endmodule

`default_nettype wire

// File: tb/tb_demux_out_seq.sv
// ============================================================================
//  Module   : tb_demux_out_seq
//  Purpose  : Directed self-checking bench for the write-back sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux_out_seq;

    localparam int W = 25;

    logic clk = 1'b0;
    logic reset;
    logic ones;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt;

    always #5 clk = ~clk;

    demux_out_seq_if #(.CANT_BITS(W)) bus ();

    demux_out_seq #(.CANT_BITS(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Stand-in for the filter arithmetic: a result derived from the live selec.
    assign bus.res = ones ? {W{1'b1}} : W'(32'(bus.selec) * 100);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag,
                              input logic signed [W-1:0] ea, eb, ec, ed, ee, ey);
        check({tag, ".a"}, 32'(bus.a), 32'(ea));
        check({tag, ".b"}, 32'(bus.b), 32'(eb));
        check({tag, ".c"}, 32'(bus.c), 32'(ec));
        check({tag, ".d"}, 32'(bus.d), 32'(ed));
        check({tag, ".e"}, 32'(bus.e), 32'(ee));
        check({tag, ".y"}, 32'(bus.y), 32'(ey));
    endtask

    function automatic logic [3:0] exp_sel(input int c);
        case (c)
            1:       return 4'b0000;
            2:       return 4'b0001;
            3:       return 4'b0010;
            4:       return 4'b0101;
            5:       return 4'b0110;
            6:       return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        ones      = 1'b0;
        step();
        step();
        reset = 1'b0;

        check("rst.selec", 32'(bus.selec), 32'h0000000F);
        check("rst.busy",  32'(bus.busy),  32'd0);
        check("rst.done",  32'(bus.done),  32'd0);
        check_regs("rst", 0, 0, 0, 0, 0, 0);

        // Idle with no start.
        for (int c = 0; c < 20; c++) begin
            check($sformatf("idle%0d.selec", c), 32'(bus.selec), 32'h0000000F);
            check($sformatf("idle%0d.busy", c),  32'(bus.busy),  32'd0);
            check($sformatf("idle%0d.done", c),  32'(bus.done),  32'd0);
            step();
        end
        check_regs("idle", 0, 0, 0, 0, 0, 0);

        // One sequence, res = selec*100.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("seq.c%0d.selec", c), 32'(bus.selec), 32'(exp_sel(c)));
            check($sformatf("seq.c%0d.done", c),  32'(bus.done),  32'(c == 7));
            check($sformatf("seq.c%0d.busy", c),  32'(bus.busy),  32'(c <= 7));
            if (c == 4) begin
                check("seq.c4.b_updated", 32'(bus.b), 32'd100);
                check("seq.c4.y_hold",    32'(bus.y), 32'd0);
            end
            if (c == 7) check("seq.c7.y", 32'(bus.y), 32'd700);
            step();
        end
        check_regs("seq", 0, 100, 200, 500, 600, 700);

        // All-ones result keeps its sign.
        ones      = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (8) step();
        check_regs("neg", -1, -1, -1, -1, -1, -1);
        ones = 1'b0;

        // Re-pulses in cycles 2 and 7 must be ignored.
        done_cnt  = 0;
        bus.start = 1'b1;
        step();
        for (int c = 1; c <= 12; c++) begin
            done_cnt += int'(bus.done);
            if (c == 8 || c == 9) check($sformatf("repulse.c%0d.busy", c), 32'(bus.busy), 32'd0);
            bus.start = (c == 2 || c == 7);
            step();
        end
        bus.start = 1'b0;
        check("repulse.done_count", 32'(done_cnt), 32'd1);

        // start held high for 20 cycles.
        check("held.c0.selec", 32'(bus.selec), 32'h0000000F);
        bus.start = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            step();
            if (c >= 20) bus.start = 1'b0;
            check($sformatf("held.c%0d.done", c), 32'(bus.done),
                  32'(c == 7 || c == 15 || c == 23));
            if (c == 7 || c == 8 || c == 15 || c == 16)
                check($sformatf("held.c%0d.selec", c), 32'(bus.selec), 32'h0000000F);
        end
        step();
        check_regs("held", 0, 100, 200, 500, 600, 700);

        // Reset in cycle 4 of a sequence.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        check("midrst.c4.selec", 32'(bus.selec), 32'h00000005);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst.selec", 32'(bus.selec), 32'h0000000F);
        check("midrst.busy",  32'(bus.busy),  32'd0);
        check_regs("midrst", 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("midrst.nodone%0d", c), 32'(bus.done), 32'd0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
